// File: rtl/aes_sched.sv
// Arbitrates two requesters onto one shared combinational AES core and holds its inputs for a multicycle settle window.
// Optional per-requester completion counters are built when AES_SCHED_PERF_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for a request; grant is combinational round-robin
// S_SETTLE | core inputs held stable while the settle down-counter runs
// S_RESP   | result held on the response channel until accepted
module aes_sched #(
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [127:0]     req0_pt,
  input  logic [127:0]     req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [127:0]     req1_pt,
  input  logic [127:0]     req1_key,
  output logic [127:0]     core_pt,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_ct,
  input  logic [127:0]     core_keyout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [127:0]     resp_ct,
  output logic [127:0]     resp_lastkey,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  // A zero or negative settle budget is treated as a single-cycle window.
  localparam int SC_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int SW     = $clog2(SC_EFF + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          id_q, id_d;
  logic          last_served_q, last_served_d;
  logic [127:0]  core_pt_q, core_pt_d;
  logic [127:0]  core_key_q, core_key_d;
  logic [127:0]  resp_ct_q, resp_ct_d;
  logic [127:0]  resp_lastkey_q, resp_lastkey_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_id_q, resp_id_d;

  logic          grant;
  logic          grant_vld;

  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_served_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = (state_q == S_IDLE) && grant_vld && !grant;
  assign req1_ready = (state_q == S_IDLE) && grant_vld && grant;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    id_d           = id_q;
    last_served_d  = last_served_q;
    core_pt_d      = core_pt_q;
    core_key_d     = core_key_q;
    resp_ct_d      = resp_ct_q;
    resp_lastkey_d = resp_lastkey_q;
    resp_valid_d   = resp_valid_q;
    resp_id_d      = resp_id_q;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          core_pt_d  = grant ? req1_pt  : req0_pt;
          core_key_d = grant ? req1_key : req0_key;
          id_d       = grant;
          cnt_d      = SW'(SC_EFF);
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SW'(1)) begin
          resp_ct_d      = core_ct;
          resp_lastkey_d = core_keyout;
          resp_id_d      = id_q;
          resp_valid_d   = 1'b1;
          state_d        = S_RESP;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d  = 1'b0;
          last_served_d = resp_id_q;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // last_served resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      id_q           <= 1'b0;
      last_served_q  <= 1'b1;
      core_pt_q      <= '0;
      core_key_q     <= '0;
      resp_ct_q      <= '0;
      resp_lastkey_q <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      id_q           <= id_d;
      last_served_q  <= last_served_d;
      core_pt_q      <= core_pt_d;
      core_key_q     <= core_key_d;
      resp_ct_q      <= resp_ct_d;
      resp_lastkey_q <= resp_lastkey_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
    end
  end

  assign core_pt      = core_pt_q;
  assign core_key     = core_key_q;
  assign resp_ct      = resp_ct_q;
  assign resp_lastkey = resp_lastkey_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign busy         = (state_q != S_IDLE);

`ifdef AES_SCHED_PERF_EN
  logic             resp_hs;
  logic [CNT_W-1:0] done_cnt0_q, done_cnt0_d;
  logic [CNT_W-1:0] done_cnt1_q, done_cnt1_d;

  assign resp_hs = (state_q == S_RESP) && resp_ready;

  // Counters saturate rather than wrap.
  always_comb begin
    done_cnt0_d = done_cnt0_q;
    done_cnt1_d = done_cnt1_q;
    if (resp_hs && !resp_id_q && !(&done_cnt0_q)) begin
      done_cnt0_d = done_cnt0_q + CNT_W'(1);
    end
    if (resp_hs && resp_id_q && !(&done_cnt1_q)) begin
      done_cnt1_d = done_cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt0_q <= '0;
      done_cnt1_q <= '0;
    end else begin
      done_cnt0_q <= done_cnt0_d;
      done_cnt1_q <= done_cnt1_d;
    end
  end

  assign done_cnt0 = done_cnt0_q;
  assign done_cnt1 = done_cnt1_q;
`else
  assign done_cnt0 = '0;
  assign done_cnt1 = '0;
`endif

endmodule

// File: tb/tb_aes_sched.sv
// Directed bench for aes_sched with a stand-in AES core that returns the FIPS-197 answer for the FIPS vector.
module tb_aes_sched;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam int           TB_CNT_W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
  logic [127:0] req0_pt = '0, req0_key = '0, req1_pt = '0, req1_key = '0;
  logic         req0_ready, req1_ready, resp_valid, resp_id, busy;
  logic [127:0] core_pt, core_key, core_ct, core_keyout, resp_ct, resp_lastkey;
  logic [TB_CNT_W-1:0] done_cnt0, done_cnt1;

  logic         a_valid = 1'b0;
  logic [127:0] a_pt = '0, a_key = '0;
  logic         s1_r0, s1_r1, s1_rv, s1_id, s1_busy;
  logic [127:0] s1_cpt, s1_ckey, s1_cct, s1_cko, s1_ct, s1_lk;
  logic [15:0]  s1_c0, s1_c1;
  logic         s0_r0, s0_r1, s0_rv, s0_id, s0_busy;
  logic [127:0] s0_cpt, s0_ckey, s0_cct, s0_cko, s0_ct, s0_lk;
  logic [15:0]  s0_c0, s0_c1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_c0 = 0;
  int exp_c1 = 0;

  always #5 clk = ~clk;

  function automatic logic [127:0] fake_ct(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a;
  endfunction

  function automatic logic [127:0] fake_lk(input logic [127:0] key);
    if (key == FIPS_KEY) return FIPS_LK;
    return ~key;
  endfunction

  assign core_ct     = fake_ct(core_pt, core_key);
  assign core_keyout = fake_lk(core_key);
  assign s1_cct      = fake_ct(s1_cpt, s1_ckey);
  assign s1_cko      = fake_lk(s1_ckey);
  assign s0_cct      = fake_ct(s0_cpt, s0_ckey);
  assign s0_cko      = fake_lk(s0_ckey);

  aes_sched #(.SETTLE_CYCLES(3), .CNT_W(TB_CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pt(req0_pt), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pt(req1_pt), .req1_key(req1_key),
    .core_pt(core_pt), .core_key(core_key), .core_ct(core_ct), .core_keyout(core_keyout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_ct(resp_ct), .resp_lastkey(resp_lastkey), .busy(busy),
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  aes_sched #(.SETTLE_CYCLES(1)) u_sc1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_valid), .req0_ready(s1_r0), .req0_pt(a_pt), .req0_key(a_key),
    .req1_valid(1'b0), .req1_ready(s1_r1), .req1_pt(128'h0), .req1_key(128'h0),
    .core_pt(s1_cpt), .core_key(s1_ckey), .core_ct(s1_cct), .core_keyout(s1_cko),
    .resp_valid(s1_rv), .resp_ready(1'b1), .resp_id(s1_id),
    .resp_ct(s1_ct), .resp_lastkey(s1_lk), .busy(s1_busy),
    .done_cnt0(s1_c0), .done_cnt1(s1_c1)
  );

  aes_sched #(.SETTLE_CYCLES(0)) u_sc0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_valid), .req0_ready(s0_r0), .req0_pt(a_pt), .req0_key(a_key),
    .req1_valid(1'b0), .req1_ready(s0_r1), .req1_pt(128'h0), .req1_key(128'h0),
    .core_pt(s0_cpt), .core_key(s0_ckey), .core_ct(s0_cct), .core_keyout(s0_cko),
    .resp_valid(s0_rv), .resp_ready(1'b1), .resp_id(s0_id),
    .resp_ct(s0_ct), .resp_lastkey(s0_lk), .busy(s0_busy),
    .done_cnt0(s0_c0), .done_cnt1(s0_c1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bump(input logic id);
`ifdef AES_SCHED_PERF_EN
    if (id) begin
      if (exp_c1 < (1 << TB_CNT_W) - 1) exp_c1++;
    end else begin
      if (exp_c0 < (1 << TB_CNT_W) - 1) exp_c0++;
    end
`else
    if (id === 1'bx) $display("note: unknown id");
`endif
  endtask

  // One complete operation on the main DUT; bp > 0 stalls the response for bp cycles.
  task automatic do_op(input logic n, input logic [127:0] pt, input logic [127:0] key,
                       input logic [127:0] exp_ct, input logic [127:0] exp_lk, input int bp);
    int lat;
    @(negedge clk);
    if (n) begin
      req1_pt = pt; req1_key = key; req1_valid = 1'b1;
    end else begin
      req0_pt = pt; req0_key = key; req0_valid = 1'b1;
    end
    resp_ready = (bp == 0);
    #1;
    chk("acc_ready", 128'(n ? req1_ready : req0_ready), 128'(1));
    chk("acc_other", 128'(n ? req0_ready : req1_ready), 128'(0));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("core_pt", core_pt, pt);
    chk("core_key", core_key, key);
    chk("busy_settle", 128'(busy), 128'(1));
    chk("rv_early", 128'(resp_valid), 128'(0));
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(3));
    chk("resp_ct", resp_ct, exp_ct);
    chk("resp_lastkey", resp_lastkey, exp_lk);
    chk("resp_id", 128'(resp_id), 128'(n));
    chk("core_pt_hold", core_pt, pt);
    if (bp > 0) begin
      if (n) req0_valid = 1'b1; else req1_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        chk("bp_valid", 128'(resp_valid), 128'(1));
        chk("bp_ct", resp_ct, exp_ct);
        chk("bp_id", 128'(resp_id), 128'(n));
        chk("bp_rdy0", 128'(req0_ready), 128'(0));
        chk("bp_rdy1", 128'(req1_ready), 128'(0));
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("hs_valid", 128'(resp_valid), 128'(0));
    chk("hs_busy", 128'(busy), 128'(0));
    bump(n);
    chk("cnt0", 128'(done_cnt0), 128'(exp_c0));
    chk("cnt1", 128'(done_cnt1), 128'(exp_c1));
    @(posedge clk); #1;
    chk("single_hs", 128'(resp_valid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int r;
    logic [127:0] ept;
    logic [127:0] ekey;
    logic exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rv", 128'(resp_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_core_pt", core_pt, 128'h0);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_ct", resp_ct, 128'h0);
    chk("rst_id", 128'(resp_id), 128'(0));
    chk("rst_cnt0", 128'(done_cnt0), 128'(0));
    chk("rst_cnt1", 128'(done_cnt1), 128'(0));
    rst_n = 1'b1;

    // SETTLE_CYCLES = 1 and 0 builds: one-cycle latency
    @(negedge clk);
    a_pt = 128'hdeadbeef_00000001_cafef00d_12345678;
    a_key = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    a_valid = 1'b1;
    #1;
    chk("p1_ready", 128'(s1_r0), 128'(1));
    chk("p0_ready", 128'(s0_r0), 128'(1));
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("p1_busy", 128'(s1_busy), 128'(1));
    chk("p0_busy", 128'(s0_busy), 128'(1));
    chk("p1_rv0", 128'(s1_rv), 128'(0));
    chk("p0_rv0", 128'(s0_rv), 128'(0));
    @(posedge clk); #1;
    chk("p1_rv", 128'(s1_rv), 128'(1));
    chk("p0_rv", 128'(s0_rv), 128'(1));
    chk("p1_ct", s1_ct, fake_ct(a_pt, a_key));
    chk("p0_ct", s0_ct, fake_ct(a_pt, a_key));
    @(posedge clk); #1;
    chk("p1_rv_done", 128'(s1_rv), 128'(0));
    chk("p0_rv_done", 128'(s0_rv), 128'(0));

    // Five requester-1 operations; counters saturate when enabled
    for (int i = 0; i < 5; i++) begin
      ept  = {4{32'h1000_0000 + 32'(i)}};
      ekey = {4{32'h0bad_0000 + 32'(i * 7)}};
      do_op(1'b1, ept, ekey, fake_ct(ept, ekey), fake_lk(ekey), 0);
    end

    // FIPS-197 vector
    do_op(1'b0, FIPS_PT, FIPS_KEY, FIPS_CT, FIPS_LK, 0);

    // Backpressure with the other requester waiting
    ept  = 128'h0123456789abcdef_fedcba9876543210;
    ekey = 128'h55aa55aa_33cc33cc_0ff00ff0_a5a5a5a5;
    do_op(1'b0, ept, ekey, fake_ct(ept, ekey), fake_lk(ekey), 10);

    // Reset in the middle of SETTLE (last served is now requester 0)
    @(negedge clk);
    req0_pt = 128'h77777777_88888888_99999999_aaaaaaaa;
    req0_key = 128'h11111111_22222222_33333333_44444444;
    req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("mr_busy_before", 128'(busy), 128'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rv", 128'(resp_valid), 128'(0));
    chk("mr_busy", 128'(busy), 128'(0));
    chk("mr_core_pt", core_pt, 128'h0);
    chk("mr_core_key", core_key, 128'h0);
    chk("mr_cnt0", 128'(done_cnt0), 128'(0));
    exp_c0 = 0;
    exp_c1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale", 128'(resp_valid), 128'(0));
    end

    // Round-robin with both requesters held valid from reset
    @(negedge clk);
    req0_pt = 128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_a3a3a3a3;
    req0_key = 128'hb0b0b0b0_b1b1b1b1_b2b2b2b2_b3b3b3b3;
    req1_pt = 128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3;
    req1_key = 128'hd0d0d0d0_d1d1d1d1_d2d2d2d2_d3d3d3d3;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("tie_r0", 128'(req0_ready), 128'(1));
    chk("tie_r1", 128'(req1_ready), 128'(0));
    g = 0;
    r = 0;
    for (int cyc = 0; cyc < 80 && r < 4; cyc++) begin
      chk("rr_excl", 128'(req0_ready & req1_ready), 128'(0));
      if (req0_ready || req1_ready) begin
        if (g < 4) chk("rr_grant", 128'(req1_ready), 128'(exp_order[g]));
        g++;
      end
      if (resp_valid) begin
        chk("rr_id", 128'(resp_id), 128'(exp_order[r]));
        chk("rr_ct", resp_ct, exp_order[r] ? fake_ct(req1_pt, req1_key) : fake_ct(req0_pt, req0_key));
        bump(exp_order[r]);
        r++;
      end
      if (r < 4) begin
        @(negedge clk); #1;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_resps", 128'(r), 128'(4));
    chk("rr_grants", 128'(g), 128'(4));
    @(posedge clk); #1;
    chk("rr_idle", 128'(busy), 128'(0));
    chk("rr_cnt0", 128'(done_cnt0), 128'(exp_c0));
    chk("rr_cnt1", 128'(done_cnt1), 128'(exp_c1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_sched.md
Name: aes_sched

Overview:
- Sequencer and arbiter that shares one combinational `aes` core (10-round, full key expansion) between two requesters.
- Registers plaintext/key into the core, holds them stable for a programmed multicycle settle window, then captures the ciphertext and final round key.
- Returns the result on a valid/ready response channel tagged with the requester ID.
- Sits between two block-level clients (e.g. DMA and CPU port) and the shared `aes` instance, which is external to this block.

Parameters:
- SETTLE_CYCLES, 3, cycles core inputs are held before outputs are sampled (multicycle-path budget); values < 1 behave as 1.
- CNT_W, 16, width of the optional per-requester completion counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_pt  in  128  requester 0 plaintext.
- req0_key  in  128  requester 0 cipher key.
- req1_valid, req1_ready, req1_pt, req1_key  same as requester 0.
- core_pt  out  128  registered plaintext to `aes`.
- core_key  out  128  registered key to `aes`.
- core_ct  in  128  `aes` cipher_text.
- core_keyout  in  128  `aes` keyout (round-10 key).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  1  0 = requester 0, 1 = requester 1.
- resp_ct  out  128  captured ciphertext.
- resp_lastkey  out  128  captured round-10 key.
- busy  out  1  high in any state other than IDLE.
- done_cnt0  out  CNT_W  completions for requester 0 (optional feature).
- done_cnt1  out  CNT_W  completions for requester 1 (optional feature).

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: state IDLE, rr_ptr = 0 (req0 has priority), all registered outputs 0.
  - resp_valid, busy, core_pt, core_key, resp_* and done_cnt* all go 0 immediately on reset assertion.
  - An in-flight operation is discarded; no response is produced for it.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - Grant logic is combinational.
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the one not equal to last_served. After reset, last_served = 1, so req0 wins the first tie.
  - reqN_ready = (state == IDLE) && grant == N. It never asserts outside IDLE and never asserts for both requesters at once.
  - On handshake at edge T: core_pt/core_key <= granted pt/key; id <= N; cnt <= SETTLE_CYCLES; go to SETTLE.
- SETTLE:
  - core_pt and core_key stay stable; cnt decrements each cycle.
  - On the edge where cnt == 1: resp_ct <= core_ct, resp_lastkey <= core_keyout, resp_id <= id, resp_valid <= 1; go to RESP.
- Latency: resp_valid rises SETTLE_CYCLES cycles after the accept edge. Default: accept at edge T, resp_valid at edge T+3.
- RESP:
  - resp_valid and resp_* are held stable until resp_ready is high.
  - On handshake: resp_valid <= 0, last_served <= resp_id, go to IDLE.
  - No new request is accepted in the handshake cycle, so minimum spacing between accepts is SETTLE_CYCLES + 2 cycles.
- A requester deasserting valid without a handshake is legal; nothing is captured.
- core_pt and core_key retain their last values in IDLE and RESP. They are not cleared.
- busy = (state != IDLE).

Optional Feature:
- Macro: AES_SCHED_PERF_EN.
- Defined:
  - done_cnt0/done_cnt1 increment on each resp handshake for the matching resp_id.
  - Counters saturate at 2^CNT_W − 1.
  - Reset clears them to 0.
- Undefined: no counter registers are built; done_cnt0 and done_cnt1 are tied to 0.

Test Plan:
- FIPS-197 vector, latency check:
  - Stimulus: req0 sends pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f; resp_ready=1.
  - Required: resp_valid exactly 3 cycles after accept; resp_ct=69c4e0d86a7b0430d8cdb78070b4c55a; resp_lastkey=13111d7fe3944a17f307a78b4d2b30c5; resp_id=0.
- Round-robin tie:
  - Stimulus: req0 and req1 held valid continuously from reset.
  - Required: grant order 0,1,0,1; resp_id alternates; no cycle has both ready signals high.
- Backpressure:
  - Stimulus: resp_ready=0 for 10 cycles after resp_valid rises.
  - Required: resp_valid, resp_ct and resp_id stable; req0_ready and req1_ready stay 0; release completes with a single handshake.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 during SETTLE.
  - Required: resp_valid=0, busy=0 and core_pt=0 immediately; after release, rr_ptr favours req0 and no stale response appears.
- Parameter edge:
  - Stimulus: SETTLE_CYCLES=1 build.
  - Required: resp_valid 1 cycle after accept; SETTLE_CYCLES=0 build behaves identically.
- Optional counters:
  - Stimulus: AES_SCHED_PERF_EN defined, CNT_W=2, five req1 operations.
  - Required: done_cnt1 = 1,2,3,3,3; done_cnt0 = 0.
  - Without the macro: both counters read 0 throughout.
